// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package dmem_arb_pkg;

  localparam int ARB_AW           = 32;
  localparam int ARB_DW           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    DBG_RD  = 2'd2
  } arb_state_e;

  // One memory access as presented on the shared port. The fields are sized
  // for the widest supported bus; the top narrows them on the way out.
  typedef struct packed {
    logic              wren;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [3:0]        mask;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '0;

endpackage

// File: rtl/dmem_bus_arbiter_starve_cnt.sv
// Saturating wait counter used to protect the debug port from core starvation.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int              W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0]    LIMIT_C = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q >= LIMIT_C);

  // Next count: clear wins over increment; hold once the limit is reached.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares one data-memory port between the core load/store path (priority)
// and a valid/ready debug port that gains priority after waiting too long.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = ARB_AW,   // must not exceed ARB_AW
  parameter int DW           = ARB_DW,   // must not exceed ARB_DW
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_core_req,
  input  logic          i_core_wren,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  input  logic [3:0]    i_core_mask,
  output logic          o_core_stall,
  output logic [DW-1:0] o_core_rdata,
  input  logic          i_dbg_vld,
  output logic          o_dbg_rdy,
  input  logic          i_dbg_wren,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  input  logic [3:0]    i_dbg_mask,
  output logic          o_dbg_rvld,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_mem_req,
  output logic          o_mem_wren,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_mask,
  input  logic [DW-1:0] i_mem_rdata
);

  arb_state_e state_q, state_d;
  mem_req_t   core_req_s, dbg_req_s, mem_req_s;
  logic       starve, dbg_win, core_win;

  assign core_req_s = '{wren: i_core_wren, addr: ARB_AW'(i_core_addr),
                        wdata: ARB_DW'(i_core_wdata), mask: i_core_mask};
  assign dbg_req_s  = '{wren: i_dbg_wren, addr: ARB_AW'(i_dbg_addr),
                        wdata: ARB_DW'(i_dbg_wdata), mask: i_dbg_mask};

  // Debug waits while valid and not granted; any grant or dropped valid restarts the wait.
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .inc_i   (i_dbg_vld),
    .clr_i   (!i_dbg_vld || o_dbg_rdy),
    .sat_o   (starve)
  );

  // Arbitration, next state and all port outputs; everything is masked during reset.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = MEM_REQ_IDLE;
    o_mem_req    = 1'b0;
    o_dbg_rdy    = 1'b0;
    o_core_stall = 1'b0;
    o_core_rdata = '0;
    o_dbg_rvld   = 1'b0;
    o_dbg_rdata  = '0;
    dbg_win      = i_dbg_vld && (!i_core_req || starve);
    core_win     = i_core_req && !dbg_win;

    if (i_rst_n) begin
      case (state_q)
        IDLE: begin
          if (dbg_win) begin
            mem_req_s    = dbg_req_s;
            o_mem_req    = 1'b1;
            o_dbg_rdy    = 1'b1;
            o_core_stall = i_core_req;       // core lost this cycle
            if (!i_dbg_wren) state_d = DBG_RD;
          end else if (core_win) begin
            mem_req_s    = core_req_s;
            o_mem_req    = 1'b1;
            o_core_stall = !i_core_wren;     // stores complete on issue
            if (!i_core_wren) state_d = CORE_RD;
          end
        end
        CORE_RD: begin
          // The held core request is answered here, not reissued.
          o_core_rdata = i_mem_rdata;
          state_d      = IDLE;
        end
        DBG_RD: begin
          o_dbg_rvld   = 1'b1;
          o_dbg_rdata  = i_mem_rdata;
          o_core_stall = i_core_req;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_mem_wren  = mem_req_s.wren;
  assign o_mem_addr  = AW'(mem_req_s.addr);
  assign o_mem_wdata = DW'(mem_req_s.wdata);
  assign o_mem_mask  = mem_req_s.mask;

  // State register; reset drops any pending read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a cycle model.
module tb_dmem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_wren, dbg_vld, dbg_wren;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [3:0]  core_mask, dbg_mask;
  logic        o_core_stall, o_dbg_rdy, o_dbg_rvld, o_mem_req, o_mem_wren;
  logic [31:0] o_core_rdata, o_dbg_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;

  int n_cmp = 0;
  int n_err = 0;

  dmem_bus_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_core_req   (core_req),
    .i_core_wren  (core_wren),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .i_core_mask  (core_mask),
    .o_core_stall (o_core_stall),
    .o_core_rdata (o_core_rdata),
    .i_dbg_vld    (dbg_vld),
    .o_dbg_rdy    (o_dbg_rdy),
    .i_dbg_wren   (dbg_wren),
    .i_dbg_addr   (dbg_addr),
    .i_dbg_wdata  (dbg_wdata),
    .i_dbg_mask   (dbg_mask),
    .o_dbg_rvld   (o_dbg_rvld),
    .o_dbg_rdata  (o_dbg_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_wren   (o_mem_wren),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pend: which read the memory is answering this cycle (0 none, 1 core, 2 debug).
  // waits: cycles the current debug request has been refused.
  localparam int P_NONE = 0, P_CORE = 1, P_DBG = 2;
  int          pend  = P_NONE;
  int          waits = 0;
  logic        m_stall = 1'b0, m_rdy = 1'b0;
  logic        e_req, e_wren, e_rdy, e_stall, e_rvld;
  logic [31:0] e_addr, e_wdata, e_drdata;
  logic [3:0]  e_mask;

  always begin
    @(negedge clk);
    #2;
    e_req = 0; e_wren = 0; e_addr = 0; e_wdata = 0; e_mask = 0;
    e_rdy = 0; e_stall = 0; e_rvld = 0; e_drdata = 0;
    if (rst_n) begin
      if (pend == P_CORE) begin
        e_stall = 0;
      end else if (pend == P_DBG) begin
        e_rvld = 1; e_drdata = mem_rdata; e_stall = core_req;
      end else if (dbg_vld && (!core_req || waits >= LIMIT)) begin
        e_req = 1; e_rdy = 1; e_stall = core_req;
        e_wren = dbg_wren; e_addr = dbg_addr; e_wdata = dbg_wdata; e_mask = dbg_mask;
      end else if (core_req) begin
        e_req = 1; e_stall = !core_wren;
        e_wren = core_wren; e_addr = core_addr; e_wdata = core_wdata; e_mask = core_mask;
      end
    end
    m_stall = e_stall;
    m_rdy   = e_rdy;
    check("mem_req",    {31'd0, o_mem_req},   {31'd0, e_req});
    check("mem_wren",   {31'd0, o_mem_wren},  {31'd0, e_wren});
    check("mem_addr",   o_mem_addr,           e_addr);
    check("mem_wdata",  o_mem_wdata,          e_wdata);
    check("mem_mask",   {28'd0, o_mem_mask},  {28'd0, e_mask});
    check("dbg_rdy",    {31'd0, o_dbg_rdy},   {31'd0, e_rdy});
    check("core_stall", {31'd0, o_core_stall},{31'd0, e_stall});
    check("dbg_rvld",   {31'd0, o_dbg_rvld},  {31'd0, e_rvld});
    check("dbg_rdata",  o_dbg_rdata,          e_drdata);
    if (rst_n && pend == P_CORE) check("core_rdata", o_core_rdata, mem_rdata);
    @(posedge clk);
    if (!rst_n) begin
      pend  = P_NONE;
      waits = 0;
    end else begin
      pend  = (e_req && !e_wren) ? (e_rdy ? P_DBG : P_CORE) : P_NONE;
      waits = (!dbg_vld || e_rdy) ? 0 : ((waits < LIMIT) ? waits + 1 : LIMIT);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    core_req = 0; core_wren = 0; core_addr = 0; core_wdata = 0; core_mask = 0;
    dbg_vld  = 0; dbg_wren  = 0; dbg_addr  = 0; dbg_wdata  = 0; dbg_mask  = 0;
    mem_rdata = 0;
  endtask

  // Core loads back-to-back while debug writes; one cycle 'gap' either drops
  // debug valid or pulses reset. Reports the first cycle debug is granted.
  task automatic starve_run(input int gap, input bit gap_rst, output int first, output logic stall_at);
    first = -1; stall_at = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      rst_n     = !(gap_rst && c == gap);
      core_req  = 1; core_wren = 0; core_addr = 32'h0000_3000; core_mask = 4'hF;
      dbg_vld   = (first < 0) && !(!gap_rst && c == gap);
      dbg_wren  = 1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'hD00D_FEED; dbg_mask = 4'hF;
      mem_rdata = $urandom;
      #1;
      if (o_dbg_rdy && first < 0) begin
        first    = c;
        stall_at = o_core_stall;
      end
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
  endtask

  int   first;
  logic stall_at;

  initial begin
    rst_n = 0;
    idle_inputs();
    // Outputs masked in reset even with both requesters active.
    @(negedge clk);
    core_req = 1; core_wren = 0; dbg_vld = 1;
    #1;
    check("rst_mem_req",  {31'd0, o_mem_req},    32'd0);
    check("rst_dbg_rdy",  {31'd0, o_dbg_rdy},    32'd0);
    check("rst_stall",    {31'd0, o_core_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle_inputs();

    // Core store completes on issue.
    @(negedge clk);
    core_req = 1; core_wren = 1; core_addr = 32'h0000_7000; core_wdata = 32'h0000_00A5; core_mask = 4'hF;
    #1;
    check("t1_mem_req",   {31'd0, o_mem_req},    32'd1);
    check("t1_stall",     {31'd0, o_core_stall}, 32'd0);
    check("t1_mem_addr",  o_mem_addr,            32'h0000_7000);
    check("t1_mem_wdata", o_mem_wdata,           32'h0000_00A5);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_idle_after", {31'd0, o_mem_req},   32'd0);

    // Core load: one stall cycle, data the next.
    @(negedge clk);
    core_req = 1; core_wren = 0; core_addr = 32'h0000_2004; core_mask = 4'hF;
    #1;
    check("t2_stall_c0",  {31'd0, o_core_stall}, 32'd1);
    check("t2_addr_c0",   o_mem_addr,            32'h0000_2004);
    @(negedge clk);
    mem_rdata = 32'h1234_5678;
    #1;
    check("t2_stall_c1",  {31'd0, o_core_stall}, 32'd0);
    check("t2_rdata_c1",  o_core_rdata,          32'h1234_5678);
    check("t2_memreq_c1", {31'd0, o_mem_req},    32'd0);
    @(negedge clk);
    idle_inputs();

    // Debug read with core idle: single rvld pulse.
    @(negedge clk);
    dbg_vld = 1; dbg_wren = 0; dbg_addr = 32'h0000_0100; dbg_mask = 4'hF;
    #1;
    check("t4_rdy_c0",   {31'd0, o_dbg_rdy},  32'd1);
    check("t4_addr_c0",  o_mem_addr,          32'h0000_0100);
    @(negedge clk);
    dbg_vld = 0; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("t4_rvld_c1",  {31'd0, o_dbg_rvld}, 32'd1);
    check("t4_rdata_c1", o_dbg_rdata,         32'hCAFE_F00D);
    @(negedge clk);
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    check("t4_rvld_c2",  {31'd0, o_dbg_rvld}, 32'd0);

    // Starvation guard: debug granted on cycle 4, core stalled then.
    starve_run(-1, 1'b0, first, stall_at);
    check("t3_first_grant", first,              32'd4);
    check("t3_core_stall",  {31'd0, stall_at},  32'd1);

    // Valid dropped for one cycle restarts the full wait.
    starve_run(3, 1'b0, first, stall_at);
    check("t6_first_grant", first,              32'd8);

    // Reset during a core read (cycle 3) drops it and clears the wait count.
    starve_run(3, 1'b1, first, stall_at);
    check("t5_first_grant", first,              32'd8);

    // Reset during a debug read: no rvld pulse.
    @(negedge clk);
    dbg_vld = 1; dbg_wren = 0; dbg_addr = 32'h0000_0180;
    @(negedge clk);
    dbg_vld = 0; rst_n = 0;
    #1;
    check("t5_dbg_rvld_rst", {31'd0, o_dbg_rvld}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("t5_dbg_rvld_after", {31'd0, o_dbg_rvld}, 32'd0);
    check("t5_memreq_after",   {31'd0, o_mem_req},  32'd0);

    // Randomized traffic obeying both handshake rules.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      if (!(core_req && m_stall)) begin
        core_req   = ($urandom_range(0, 9) < 7);
        core_wren  = 1'($urandom_range(0, 1));
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_mask  = 4'($urandom_range(0, 15));
      end
      if (!(dbg_vld && !m_rdy)) begin
        dbg_vld   = 1'($urandom_range(0, 1));
        dbg_wren  = 1'($urandom_range(0, 1));
        dbg_addr  = $urandom;
        dbg_wdata = $urandom;
        dbg_mask  = 4'($urandom_range(0, 15));
      end
      mem_rdata = $urandom;
    end

    @(negedge clk);
    idle_inputs();
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
